// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants, BTB counter encoding and update-bus type for the fetch stage.
// Counter helpers keep the 2-bit saturating predictor rules in one place.
package pc_fetch_unit_pkg;

  localparam int                DATA_WID            = 32;
  localparam logic [31:0]       RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam int                BTB_ENTRIES_DEFAULT = 16;

  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic                valid;
    logic [DATA_WID-1:0] pc;
    logic                taken;
    logic [DATA_WID-1:0] target;
  } btb_upd_t;

  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    ctr_t nxt;
    case (cur)
      CTR_STRONG_NT: nxt = taken ? CTR_WEAK_NT  : CTR_STRONG_NT;
      CTR_WEAK_NT:   nxt = taken ? CTR_WEAK_T   : CTR_STRONG_NT;
      CTR_WEAK_T:    nxt = taken ? CTR_STRONG_T : CTR_WEAK_NT;
      CTR_STRONG_T:  nxt = taken ? CTR_STRONG_T : CTR_WEAK_T;
      default:       nxt = CTR_WEAK_NT;
    endcase
    return nxt;
  endfunction

  function automatic logic ctr_predicts_taken(input ctr_t cur);
    return (cur == CTR_WEAK_T) || (cur == CTR_STRONG_T);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup, posedge training.
// Lookup sees pre-update contents when lookup and update collide on one index.
module pc_fetch_unit_btb
  import pc_fetch_unit_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_WID-1:0] lookup_pc,
  output logic                hit,
  output logic                taken,
  output logic [DATA_WID-1:0] target,
  input  btb_upd_t            upd
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = DATA_WID - IDX_W - 2;

  logic                valid_r  [ENTRIES];
  logic [TAG_W-1:0]    tag_r    [ENTRIES];
  logic [DATA_WID-1:0] target_r [ENTRIES];
  ctr_t                ctr_r    [ENTRIES];

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic [IDX_W-1:0] up_idx_s;
  logic [TAG_W-1:0] up_tag_s;
  logic             up_hit_s;
  logic             unused_low_bits_s;

  assign lk_idx_s = lookup_pc[IDX_W+1:2];
  assign lk_tag_s = lookup_pc[DATA_WID-1:IDX_W+2];
  assign up_idx_s = upd.pc[IDX_W+1:2];
  assign up_tag_s = upd.pc[DATA_WID-1:IDX_W+2];

  // Byte-offset bits never take part in indexing or tag match.
  assign unused_low_bits_s = ^{lookup_pc[1:0], upd.pc[1:0]};

  assign hit      = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
  assign taken    = hit && ctr_predicts_taken(ctr_r[lk_idx_s]);
  assign target   = target_r[lk_idx_s];
  assign up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);

  // Entry storage: reset invalidates all, resolved branches train or allocate.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {DATA_WID{1'b0}};
        ctr_r[i]    <= CTR_WEAK_NT;
      end
    end else if (upd.valid) begin
      if (up_hit_s) begin
        ctr_r[up_idx_s] <= ctr_next(ctr_r[up_idx_s], upd.taken);
        if (upd.taken) begin
          target_r[up_idx_s] <= upd.target;
        end
      end else if (upd.taken) begin
        valid_r[up_idx_s]  <= 1'b1;
        tag_r[up_idx_s]    <= up_tag_s;
        target_r[up_idx_s] <= upd.target;
        ctr_r[up_idx_s]    <= CTR_WEAK_T;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the I-cache address and
// presents instruction, PC and BTB prediction to the IF/ID register.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                  BTB_ENTRIES = BTB_ENTRIES_DEFAULT,
  parameter logic [DATA_WID-1:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                icache_stall,
  input  logic                dcache_stall,
  input  logic                pc_hold,
  input  logic                predict_fail,
  input  logic [DATA_WID-1:0] correct_pc,
  input  logic                upd_valid,
  input  logic [DATA_WID-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [DATA_WID-1:0] upd_target,
  input  logic [DATA_WID-1:0] inst_in,
  output logic [DATA_WID-1:0] icache_addr,
  output logic [DATA_WID-1:0] inst_out,
  output logic [DATA_WID-1:0] pc_out,
  output logic                predict_out,
  output logic [DATA_WID-1:0] predict_pc_out
);

  logic [DATA_WID-1:0] pc_r;
  logic [DATA_WID-1:0] pc_next_s;
  logic [DATA_WID-1:0] btb_target_s;
  logic                btb_taken_s;
  logic                unused_btb_hit_s;
  btb_upd_t            upd_s;

  assign upd_s = '{valid: upd_valid, pc: upd_pc, taken: upd_taken, target: upd_target};

  pc_fetch_unit_btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .lookup_pc (pc_r),
    .hit       (unused_btb_hit_s),
    .taken     (btb_taken_s),
    .target    (btb_target_s),
    .upd       (upd_s)
  );

  assign icache_addr    = pc_r;
  assign pc_out         = pc_r;
  assign inst_out       = inst_in;
  assign predict_out    = btb_taken_s;
  assign predict_pc_out = btb_taken_s ? btb_target_s : (pc_r + 32'd4);

  // Next-PC select: a redirect from EX overrides every stall source.
  always_comb begin
    pc_next_s = predict_pc_out;
    if (predict_fail) begin
      pc_next_s = correct_pc;
    end else if (icache_stall || dcache_stall || pc_hold) begin
      pc_next_s = pc_r;
    end else begin
      pc_next_s = predict_pc_out;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by random
// traffic, all compared against a table-based behavioural predictor model.
module tb_pc_fetch_unit;

  localparam int          N        = 16;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, icache_stall, dcache_stall, pc_hold, predict_fail;
  logic [31:0] correct_pc, upd_pc, upd_target, inst_in;
  logic        upd_valid, upd_taken;
  logic [31:0] icache_addr, inst_out, pc_out, predict_pc_out;
  logic        predict_out;

  int checks = 0;
  int errors = 0;

  // Reference model: one slot per BTB line, counter kept as integer 0..3.
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  logic [31:0] m_pc;
  bit          m_known = 1'b0;

  pc_fetch_unit #(.BTB_ENTRIES(N), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_stall   (icache_stall),
    .dcache_stall   (dcache_stall),
    .pc_hold        (pc_hold),
    .predict_fail   (predict_fail),
    .correct_pc     (correct_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .inst_in        (inst_in),
    .icache_addr    (icache_addr),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .predict_out    (predict_out),
    .predict_pc_out (predict_pc_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'd4) % N);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (32'd4 * N);
  endfunction

  function automatic bit m_pred_taken(input logic [31:0] a);
    int i = line_of(a);
    return m_valid[i] && (m_tag[i] == tag_of(a)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_pc(input logic [31:0] a);
    return m_pred_taken(a) ? m_tgt[line_of(a)] : a + 32'd4;
  endfunction

  // One clock: apply inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic cycle(input logic r, input logic ic, input logic dc, input logic ph,
                       input logic pf, input logic [31:0] cpc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utg);
    logic [31:0] nxt;
    int i;
    rst = r; icache_stall = ic; dcache_stall = dc; pc_hold = ph;
    predict_fail = pf; correct_pc = cpc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utg; inst_in = $urandom;
    @(negedge clk);
    if (m_known) begin
      check_eq("icache_addr", icache_addr, m_pc);
      check_eq("pc_out", pc_out, m_pc);
      check_eq("inst_out", inst_out, inst_in);
      check_eq("predict_out", {31'd0, predict_out}, {31'd0, m_pred_taken(m_pc)});
      check_eq("predict_pc_out", predict_pc_out, m_pred_pc(m_pc));
    end
    if (r) begin
      for (int k = 0; k < N; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 1;
      end
      m_pc    = RST_PC;
      m_known = 1'b1;
    end else begin
      if (pf)                nxt = cpc;
      else if (ic || dc || ph) nxt = m_pc;
      else                   nxt = m_pred_pc(m_pc);
      if (uv) begin
        i = line_of(upc);
        if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
          if (ut) begin
            m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = utg;
          end else begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
          end
        end else if (ut) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = tag_of(upc);
          m_tgt[i]   = utg;
          m_ctr[i]   = 2;
        end
      end
      m_pc = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic redirect(input logic [31:0] a);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic train(input logic [31:0] a, input logic t, input logic [31:0] tg);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, a, t, tg);
  endtask

  initial begin
    logic r, ic, dc, ph, pf, uv, ut;
    logic [31:0] cpc, upc, utg;

    rst = 1'b1; icache_stall = 1'b0; dcache_stall = 1'b0; pc_hold = 1'b0;
    predict_fail = 1'b0; correct_pc = 32'd0; upd_valid = 1'b0; upd_pc = 32'd0;
    upd_taken = 1'b0; upd_target = 32'd0; inst_in = 32'd0;
    @(posedge clk);
    #1;

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("reset_addr", icache_addr, 32'h0);
    check_eq("reset_ppc", predict_pc_out, 32'h4);

    // Sequential fetch 0,4,8 then train 0x10 taken while at 0xC.
    idle(); idle(); idle();
    train(32'h10, 1'b1, 32'h40);
    check_eq("hit_addr", icache_addr, 32'h10);
    check_eq("hit_pred", {31'd0, predict_out}, 32'd1);
    check_eq("hit_ppc", predict_pc_out, 32'h40);
    idle();
    check_eq("taken_follow", icache_addr, 32'h40);

    // Two not-taken updates: 10 -> 01 -> 00.
    train(32'h10, 1'b0, 32'h0);
    train(32'h10, 1'b0, 32'h0);
    redirect(32'h10);
    check_eq("nt_pred", {31'd0, predict_out}, 32'd0);
    check_eq("nt_ppc", predict_pc_out, 32'h14);
    train(32'h10, 1'b1, 32'h40);
    redirect(32'h10);
    check_eq("weak_nt_pred", {31'd0, predict_out}, 32'd0);

    // Alias at same line, different tag.
    train(32'h50, 1'b1, 32'h80);
    redirect(32'h10);
    check_eq("alias_ppc", predict_pc_out, 32'h14);
    redirect(32'h50);
    check_eq("alias_hit_ppc", predict_pc_out, 32'h80);

    // I-cache stall, then redirect during a D-cache stall.
    redirect(32'h20);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      check_eq("icache_hold", icache_addr, 32'h20);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("redirect_over_stall", icache_addr, 32'h100);

    // pc_hold with a same-line update: PC held, prediction visible next cycle.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h100, 1'b1, 32'h200);
    check_eq("hold_addr", icache_addr, 32'h100);
    check_eq("hold_pred", {31'd0, predict_out}, 32'd1);
    check_eq("hold_ppc", predict_pc_out, 32'h200);

    // Random traffic over a small address window so lines get reused and aliased.
    for (int n = 0; n < 800; n++) begin
      r   = ($urandom_range(0, 99) == 0);
      ic  = ($urandom_range(0, 7) == 0);
      dc  = ($urandom_range(0, 9) == 0);
      ph  = ($urandom_range(0, 9) == 0);
      pf  = ($urandom_range(0, 5) == 0);
      cpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)
                                        : 32'($urandom_range(0, 127) * 4);
      uv  = ($urandom_range(0, 2) == 0);
      upc = ($urandom_range(0, 1) == 0) ? m_pc : 32'($urandom_range(0, 127) * 4);
      ut  = $urandom_range(0, 1) == 1;
      utg = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127) * 4);
      cycle(r, ic, dc, ph, pf, cpc, uv, upc, ut, utg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
